// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths and FSM state encoding for the instruction-fetch memory controller.
package if_fetch_ctrl_pkg;

    localparam int ADDR_LEN     = 32;
    localparam int INSN_LEN     = 32;
    localparam int LINE_TAG_LEN = ADDR_LEN - 4;
    localparam int LINE_LEN     = 4 * INSN_LEN;

    typedef enum logic [1:0] {
        FCTL_ST_IDLE  = 2'd0,
        FCTL_ST_REQ   = 2'd1,
        FCTL_ST_WAIT  = 2'd2,
        FCTL_ST_VALID = 2'd3
    } fctl_state_e;

endpackage

// File: rtl/fetch_line_buf.sv
// One-entry line buffer: holds the last accepted imem line and its tag, and reports
// whether a candidate line address hits the buffered line.
module fetch_line_buf
    import if_fetch_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [LINE_TAG_LEN-1:0] wr_line,
    input  logic [LINE_LEN-1:0]     wr_data,
    input  logic [LINE_TAG_LEN-1:0] cmp_line,
    output logic [LINE_LEN-1:0]     rd_data,
    output logic [LINE_TAG_LEN-1:0] buf_line,
    output logic                    hit
);

    logic [LINE_LEN-1:0]     line_buf_q, line_buf_d;
    logic [LINE_TAG_LEN-1:0] buf_line_q, buf_line_d;

    always_comb begin
        line_buf_d = line_buf_q;
        buf_line_d = buf_line_q;
        if (wr_en) begin
            line_buf_d = wr_data;
            buf_line_d = wr_line;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_buf_q <= '0;
            buf_line_q <= '0;
        end else begin
            line_buf_q <= line_buf_d;
            buf_line_q <= buf_line_d;
        end
    end

    assign rd_data  = line_buf_q;
    assign buf_line = buf_line_q;
    assign hit      = (cmp_line == buf_line_q);

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-side imem sequencer: owns the fetch PC, issues one line request at a time,
// buffers the returned line and drops responses made stale by a redirect.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int                  CNT_LEN  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_LEN-1:0]     npc,
    input  logic                    stall_if,
    input  logic                    redirect,
    input  logic [ADDR_LEN-1:0]     redirect_pc,
    output logic [ADDR_LEN-1:0]     pc,
    output logic [LINE_LEN-1:0]     idata,
    output logic                    fetch_valid,
    output logic                    imem_req,
    output logic [LINE_TAG_LEN-1:0] imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [LINE_LEN-1:0]     imem_rdata,
    output logic [CNT_LEN-1:0]      miss_cnt,
    output logic [CNT_LEN-1:0]      drop_cnt
);

    fctl_state_e             state_q, state_d;
    logic [ADDR_LEN-1:0]     pc_q, pc_d;
    logic [LINE_TAG_LEN-1:0] req_line_q, req_line_d;
    logic                    drop_pend_q, drop_pend_d;
    logic [CNT_LEN-1:0]      miss_cnt_q, miss_cnt_d;
    logic [CNT_LEN-1:0]      drop_cnt_q, drop_cnt_d;

    logic                    buf_wr;
    logic                    buf_hit;
    logic [LINE_TAG_LEN-1:0] buf_line;
    logic [LINE_TAG_LEN-1:0] cmp_line;
    logic [LINE_TAG_LEN-1:0] redirect_line;
    logic                    redirect_new_line;

    assign redirect_line     = redirect_pc[ADDR_LEN-1:4];
    // A redirect away from the in-flight line makes its eventual response stale.
    assign redirect_new_line = redirect && (redirect_line != req_line_q);
    assign cmp_line          = redirect ? redirect_line : npc[ADDR_LEN-1:4];

    fetch_line_buf u_line_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (buf_wr),
        .wr_line  (req_line_q),
        .wr_data  (imem_rdata),
        .cmp_line (cmp_line),
        .rd_data  (idata),
        .buf_line (buf_line),
        .hit      (buf_hit)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_line_d  = req_line_q;
        drop_pend_d = drop_pend_q;
        miss_cnt_d  = miss_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        buf_wr      = 1'b0;

        case (state_q)
            FCTL_ST_IDLE: begin
                state_d = FCTL_ST_REQ;
            end
            FCTL_ST_REQ: begin
                if (redirect) pc_d = redirect_pc;
                if (redirect_new_line) drop_pend_d = 1'b1;
                if (imem_gnt) begin
                    state_d    = FCTL_ST_WAIT;
                    miss_cnt_d = miss_cnt_q + CNT_LEN'(1);
                end
            end
            FCTL_ST_WAIT: begin
                if (redirect) pc_d = redirect_pc;
                if (redirect_new_line) drop_pend_d = 1'b1;
                if (imem_rvalid) begin
                    if (drop_pend_q || redirect_new_line) begin
                        drop_cnt_d  = drop_cnt_q + CNT_LEN'(1);
                        drop_pend_d = 1'b0;
                        state_d     = FCTL_ST_REQ;
                    end else begin
                        buf_wr  = 1'b1;
                        state_d = FCTL_ST_VALID;
                    end
                end
            end
            FCTL_ST_VALID: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = buf_hit ? FCTL_ST_VALID : FCTL_ST_REQ;
                end else if (!stall_if) begin
                    pc_d    = npc;
                    state_d = buf_hit ? FCTL_ST_VALID : FCTL_ST_REQ;
                end
            end
            default: begin
                state_d = FCTL_ST_IDLE;
            end
        endcase

        // The request line is latched only on REQ entry so imem_addr stays stable until gnt.
        if (state_d == FCTL_ST_REQ && state_q != FCTL_ST_REQ) begin
            req_line_d = pc_d[ADDR_LEN-1:4];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FCTL_ST_IDLE;
            pc_q        <= RESET_PC;
            req_line_q  <= '0;
            drop_pend_q <= 1'b0;
            miss_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_line_q  <= req_line_d;
            drop_pend_q <= drop_pend_d;
            miss_cnt_q  <= miss_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == FCTL_ST_VALID);
    assign imem_req    = (state_q == FCTL_ST_REQ);
    assign imem_addr   = req_line_q;
    assign miss_cnt    = miss_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
